// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg
//   Shared types and width helpers for the conv_top sequencer.
//   - ctrl_state_t : sequencer FSM state encoding
//   - cnt_w        : index width for a counter spanning 0..n-1 (min 1 bit)
//   - sat_cnt_w    : width for a counter spanning 0..n inclusive
//   - npix         : output pixels per frame
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    KWAIT,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int DEF_OF_WIDTH  = 128;
  localparam int DEF_OF_HEIGHT = 128;
  localparam int DEF_IF_PORT   = 27;
  localparam int DEF_K_NUM     = 3;
  localparam int DEF_K_LEN     = 27;
  localparam int DEF_RD_LAT    = 1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sat_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int npix(input int w, input int h);
    return w * h;
  endfunction

  localparam int DEF_NPIX = npix(DEF_OF_WIDTH, DEF_OF_HEIGHT);

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line
//   1-bit shift register; taps_o[i] is d_i delayed (FIRST_TAP + i) cycles.
//   DEPTH must equal FIRST_TAP + TAPS - 1 (the last tap is the oldest stage).
//   Ports:
//     clk, rst  : clock, async active-high reset
//     clr_i     : synchronous clear of every stage (wins over shifting)
//     d_i       : serial input
//     taps_o    : delayed copies of d_i
module skew_delay_line #(
  parameter int DEPTH     = 1,
  parameter int TAPS      = 1,
  parameter int FIRST_TAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            d_i,
  output logic [TAPS-1:0] taps_o
);

  // Stage k holds d_i delayed k cycles.
  logic [DEPTH:1] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[1] = d_i;
    if (clr_i) sr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign taps_o = sr_q[FIRST_TAP+TAPS-1 -: TAPS];

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
//   Sequencer for the conv_top systolic MAC array: kernel prefetch, then a
//   raster scan of output pixels with one im2col fetch each, then waits for
//   the last lane to report every pixel before pulsing done.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start
//   KLOAD  | reading K_LEN weights, one address per cycle
//   KWAIT  | RD_LAT cycles so the last weight lands in the array
//   STREAM | one im2col request per cycle, raster order, no bubbles
//   DRAIN  | requests done; waiting for of_cnt to reach NPIX
//   DONE   | one-cycle done pulse, busy already low
//
//   Ports:
//     clk, rst          : clock, async active-high reset
//     start, abort      : host command pulse, synchronous abort
//     busy, done        : run in progress, completion pulse
//     k_rd_en/k_rd_addr : kernel SRAM read strobe and weight index
//     k_prefetch        : array prefetch enable aligned with weight data
//     k_valid_o         : array k_i_valid (all lanes equal)
//     if_rd_en/x/y      : im2col fetch request and output pixel coordinate
//     if_valid_o        : per-port skewed array if_i_valid
//     of_valid_i        : array of_o_valid
//     of_cnt            : completed pixels counted on the last lane
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int OF_WIDTH  = DEF_OF_WIDTH,
  parameter int OF_HEIGHT = DEF_OF_HEIGHT,
  parameter int IF_PORT   = DEF_IF_PORT,
  parameter int K_NUM     = DEF_K_NUM,
  parameter int K_LEN     = DEF_K_LEN,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       abort,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       k_rd_en,
  output logic [cnt_w(K_LEN)-1:0]                    k_rd_addr,
  output logic                                       k_prefetch,
  output logic [K_NUM-1:0]                           k_valid_o,
  output logic                                       if_rd_en,
  output logic [cnt_w(OF_WIDTH)-1:0]                 if_rd_x,
  output logic [cnt_w(OF_HEIGHT)-1:0]                if_rd_y,
  output logic [IF_PORT-1:0]                         if_valid_o,
  input  logic [K_NUM-1:0]                           of_valid_i,
  output logic [sat_cnt_w(OF_WIDTH*OF_HEIGHT)-1:0]   of_cnt
);

  localparam int NPIX = npix(OF_WIDTH, OF_HEIGHT);
  localparam int AW   = cnt_w(K_LEN);
  localparam int XW   = cnt_w(OF_WIDTH);
  localparam int YW   = cnt_w(OF_HEIGHT);
  localparam int WW   = cnt_w(RD_LAT);
  localparam int CW   = sat_cnt_w(NPIX);

  ctrl_state_t   state_q, state_d;
  logic [AW-1:0] kaddr_q, kaddr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] of_cnt_q, of_cnt_d;
  logic          abort_act;
  logic          k_pref;

  // Only the last lane is counted; the others finish no later.
  logic unused_lanes;
  assign unused_lanes = ^of_valid_i;

  assign abort_act = abort && (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    kaddr_d  = kaddr_q;
    wait_d   = wait_q;
    x_d      = x_q;
    y_d      = y_q;
    of_cnt_d = of_cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    k_rd_en  = 1'b0;
    if_rd_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = KLOAD;
      end
      KLOAD: begin
        busy    = 1'b1;
        k_rd_en = 1'b1;
        if (kaddr_q == AW'(K_LEN - 1)) begin
          kaddr_d = '0;
          wait_d  = WW'(RD_LAT - 1);
          state_d = KWAIT;
        end else begin
          kaddr_d = kaddr_q + 1'b1;
        end
      end
      KWAIT: begin
        busy = 1'b1;
        // Down-counter loaded with RD_LAT-1: exit on terminal count zero.
        if (wait_q == '0) state_d = STREAM;
        else              wait_d  = wait_q - 1'b1;
      end
      STREAM: begin
        busy     = 1'b1;
        if_rd_en = 1'b1;
        if (x_q == XW'(OF_WIDTH - 1)) begin
          x_d = '0;
          if (y_q == YW'(OF_HEIGHT - 1)) begin
            y_d     = '0;
            state_d = DRAIN;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (of_cnt_q == CW'(NPIX)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_act) begin
      state_d = IDLE;
      kaddr_d = '0;
      wait_d  = '0;
      x_d     = '0;
      y_d     = '0;
    end

    if (state_q == IDLE && state_d == KLOAD)
      of_cnt_d = '0;
    else if (of_valid_i[K_NUM-1] && of_cnt_q != CW'(NPIX))
      of_cnt_d = of_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      kaddr_q  <= '0;
      wait_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      of_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      kaddr_q  <= kaddr_d;
      wait_q   <= wait_d;
      x_q      <= x_d;
      y_q      <= y_d;
      of_cnt_q <= of_cnt_d;
    end
  end

  skew_delay_line #(
    .DEPTH     (RD_LAT),
    .TAPS      (1),
    .FIRST_TAP (RD_LAT)
  ) u_k_dly (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort_act),
    .d_i    (k_rd_en),
    .taps_o (k_pref)
  );

  // Keeps shifting through DRAIN so the skew tail empties on its own.
  skew_delay_line #(
    .DEPTH     (RD_LAT + IF_PORT - 1),
    .TAPS      (IF_PORT),
    .FIRST_TAP (RD_LAT)
  ) u_if_dly (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort_act),
    .d_i    (if_rd_en),
    .taps_o (if_valid_o)
  );

  assign k_prefetch = k_pref;
  assign k_valid_o  = {K_NUM{k_pref}};
  assign k_rd_addr  = kaddr_q;
  assign if_rd_x    = x_q;
  assign if_rd_y    = y_q;
  assign of_cnt     = of_cnt_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;
  import conv_ctrl_pkg::*;

  typedef struct {
    int c;
    int a;
    int b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [2:0] of_valid_i = '0;

  logic        busy, done, k_rd_en, k_prefetch, if_rd_en;
  logic [4:0]  k_rd_addr;
  logic [2:0]  k_valid_o;
  logic [1:0]  if_rd_x, if_rd_y;
  logic [26:0] if_valid_o;
  logic [4:0]  of_cnt;

  logic start3 = 1'b0;
  logic abort3 = 1'b0;
  logic [2:0] ov3 = '0;
  logic        busy3, done3, k_rd_en3, k_prefetch3, if_rd_en3;
  logic [4:0]  k_rd_addr3;
  logic [2:0]  k_valid3;
  logic [1:0]  if_rd_x3, if_rd_y3;
  logic [26:0] if_valid3;
  logic [4:0]  of_cnt3;

  int cyc = 0;
  int t0 = 0;
  int n_vec = 0;
  int n_err = 0;
  logic busy_prev = 1'b0;
  logic [4:0] cnt_prev = '0;

  ev_t q_krd[$], q_kpf[$], q_ifr[$], q_if0[$], q_if26[$];
  ev_t q_busy[$], q_cnt[$], q_done[$];

  conv_seq_ctrl #(
    .OF_WIDTH(4), .OF_HEIGHT(4), .IF_PORT(27), .K_NUM(3), .K_LEN(27), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr),
    .k_prefetch(k_prefetch), .k_valid_o(k_valid_o),
    .if_rd_en(if_rd_en), .if_rd_x(if_rd_x), .if_rd_y(if_rd_y),
    .if_valid_o(if_valid_o), .of_valid_i(of_valid_i), .of_cnt(of_cnt)
  );

  conv_seq_ctrl #(
    .OF_WIDTH(4), .OF_HEIGHT(4), .IF_PORT(27), .K_NUM(3), .K_LEN(27), .RD_LAT(3)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .busy(busy3), .done(done3),
    .k_rd_en(k_rd_en3), .k_rd_addr(k_rd_addr3),
    .k_prefetch(k_prefetch3), .k_valid_o(k_valid3),
    .if_rd_en(if_rd_en3), .if_rd_x(if_rd_x3), .if_rd_y(if_rd_y3),
    .if_valid_o(if_valid3), .of_valid_i(ov3), .of_cnt(of_cnt3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(input int c, input int a, input int b);
    ev_t e;
    e.c = c;
    e.a = a;
    e.b = b;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm, input int r);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at rel cycle %0d, expected none", nm, r);
  endtask

  // Expected request/valid timeline relative to the start cycle (RD_LAT=1).
  task automatic push_seq(input int nk, input int nkp, input int nif,
                          input int n0, input int n26);
    for (int i = 0; i < nk; i++)  q_krd.push_back(mk(1 + i, i, 0));
    for (int i = 0; i < nkp; i++) q_kpf.push_back(mk(2 + i, 0, 0));
    for (int i = 0; i < nif; i++) q_ifr.push_back(mk(29 + i, i % 4, i / 4));
    for (int i = 0; i < n0; i++)  q_if0.push_back(mk(30 + i, 0, 0));
    for (int i = 0; i < n26; i++) q_if26.push_back(mk(56 + i, 0, 0));
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    int r;
    ev_t e;
    r = cyc - t0;
    if (k_rd_en === 1'b1) begin
      if (q_krd.size() == 0) unexp("k_rd_en", r);
      else begin
        e = q_krd.pop_front();
        chk("krd_cycle", r, e.c);
        chk("krd_addr", int'(k_rd_addr), e.a);
      end
    end
    if (k_prefetch === 1'b1) begin
      if (q_kpf.size() == 0) unexp("k_prefetch", r);
      else begin
        e = q_kpf.pop_front();
        chk("kpf_cycle", r, e.c);
        chk("k_valid_o", int'(k_valid_o), 7);
      end
    end
    if (if_rd_en === 1'b1) begin
      if (q_ifr.size() == 0) unexp("if_rd_en", r);
      else begin
        e = q_ifr.pop_front();
        chk("ifr_cycle", r, e.c);
        chk("ifr_x", int'(if_rd_x), e.a);
        chk("ifr_y", int'(if_rd_y), e.b);
      end
    end
    if (if_valid_o[0] === 1'b1) begin
      if (q_if0.size() == 0) unexp("if_valid_o[0]", r);
      else begin
        e = q_if0.pop_front();
        chk("if0_cycle", r, e.c);
      end
    end
    if (if_valid_o[26] === 1'b1) begin
      if (q_if26.size() == 0) unexp("if_valid_o[26]", r);
      else begin
        e = q_if26.pop_front();
        chk("if26_cycle", r, e.c);
      end
    end
    if (k_prefetch === 1'b1 || |if_valid_o)
      chk("kpf_if_overlap", int'(k_prefetch && (|if_valid_o)), 0);
    if (done === 1'b1) begin
      if (q_done.size() == 0) unexp("done", r);
      else begin
        e = q_done.pop_front();
        chk("done_cycle", r, e.c);
        chk("done_busy", int'(busy), 0);
      end
    end
    if (busy !== busy_prev) begin
      if (q_busy.size() == 0) unexp("busy_edge", r);
      else begin
        e = q_busy.pop_front();
        chk("busy_cycle", r, e.c);
        chk("busy_val", int'(busy), e.a);
      end
      busy_prev = busy;
    end
    if (of_cnt !== cnt_prev) begin
      if (q_cnt.size() == 0) unexp("of_cnt_change", r);
      else begin
        e = q_cnt.pop_front();
        chk("cnt_cycle", r, e.c);
        chk("cnt_val", int'(of_cnt), e.a);
      end
      cnt_prev = of_cnt;
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_k_rd_en", int'(k_rd_en), 0);
    chk("rst_if_rd_en", int'(if_rd_en), 0);
    chk("rst_if_valid", int'(if_valid_o), 0);
    chk("rst_of_cnt", int'(of_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full run; lanes 0/1 alone must not count, 18 last-lane pulses saturate at 16
    start_pulse();
    push_seq(27, 27, 16, 16, 16);
    q_busy.push_back(mk(1, 1, 0));
    q_busy.push_back(mk(77, 0, 0));
    q_done.push_back(mk(77, 0, 0));
    for (int i = 0; i < 16; i++) q_cnt.push_back(mk(61 + i, i + 1, 0));
    for (int r = 1; r <= 85; r++) begin
      if (r >= 60 && r <= 77)      of_valid_i = 3'b111;
      else if (r >= 55 && r <= 59) of_valid_i = 3'b011;
      else                         of_valid_i = 3'b000;
      start = (r == 40);
      @(posedge clk); #1;
    end
    start = 1'b0;
    of_valid_i = '0;
    @(negedge clk);
    chk("sat_of_cnt", int'(of_cnt), 16);

    // start together with abort in IDLE is dropped
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_krd", int'(k_rd_en), 0);

    // Abort at the 7th request; restart clears of_cnt
    start_pulse();
    push_seq(27, 27, 7, 6, 0);
    q_cnt.push_back(mk(1, 0, 0));
    q_cnt.push_back(mk(11, 1, 0));
    q_cnt.push_back(mk(12, 2, 0));
    q_cnt.push_back(mk(13, 3, 0));
    q_busy.push_back(mk(1, 1, 0));
    q_busy.push_back(mk(36, 0, 0));
    for (int r = 1; r <= 60; r++) begin
      of_valid_i = (r >= 10 && r <= 12) ? 3'b100 : 3'b000;
      abort = (r == 35);
      if (r == 36) begin
        @(negedge clk);
        chk("abort_if_valid", int'(if_valid_o), 0);
        chk("abort_kpf", int'(k_prefetch), 0);
        chk("abort_state", int'(dut.state_q), int'(IDLE));
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    of_valid_i = '0;

    // Asynchronous reset in the middle of KLOAD
    start_pulse();
    push_seq(10, 9, 0, 0, 0);
    q_cnt.push_back(mk(1, 0, 0));
    q_cnt.push_back(mk(4, 1, 0));
    q_cnt.push_back(mk(5, 2, 0));
    q_cnt.push_back(mk(11, 0, 0));
    q_busy.push_back(mk(1, 1, 0));
    q_busy.push_back(mk(11, 0, 0));
    for (int r = 1; r <= 9; r++) begin
      of_valid_i = (r == 3 || r == 4) ? 3'b100 : 3'b000;
      @(posedge clk); #1;
    end
    of_valid_i = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_k_rd_en", int'(k_rd_en), 0);
    chk("arst_k_rd_addr", int'(k_rd_addr), 0);
    chk("arst_k_prefetch", int'(k_prefetch), 0);
    chk("arst_k_valid", int'(k_valid_o), 0);
    chk("arst_if_rd_en", int'(if_rd_en), 0);
    chk("arst_if_xy", int'({if_rd_x, if_rd_y}), 0);
    chk("arst_if_valid", int'(if_valid_o), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_of_cnt", int'(of_cnt), 0);
    chk("arst_state", int'(dut.state_q), int'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // RD_LAT = 3 instance: alignment windows relative to its start cycle
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int r = 1; r <= 64; r++) begin
      @(negedge clk);
      chk("d3_k_rd_en", int'(k_rd_en3), int'(r >= 1 && r <= 27));
      chk("d3_k_prefetch", int'(k_prefetch3), int'(r >= 4 && r <= 30));
      chk("d3_if_rd_en", int'(if_rd_en3), int'(r >= 31 && r <= 46));
      chk("d3_if_valid0", int'(if_valid3[0]), int'(r >= 34 && r <= 49));
      chk("d3_if_valid26", int'(if_valid3[26]), int'(r == 60));
      chk("d3_overlap", int'(k_prefetch3 && (|if_valid3)), 0);
      chk("d3_busy", int'(busy3), int'(r <= 60));
      abort3 = (r == 60);
    end
    abort3 = 1'b0;

    @(negedge clk);
    chk("left_krd", q_krd.size(), 0);
    chk("left_kpf", q_kpf.size(), 0);
    chk("left_ifr", q_ifr.size(), 0);
    chk("left_if0", q_if0.size(), 0);
    chk("left_if26", q_if26.size(), 0);
    chk("left_busy", q_busy.size(), 0);
    chk("left_cnt", q_cnt.size(), 0);
    chk("left_done", q_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
